// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Optional accumulate mode: SERIAL_ADDER_ACC_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int WIDTH_DEF = 4;

  // Counter must hold WIDTH-1 with headroom for any legal WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Single 1-bit full-adder cell shared by every bit position.
// Purely combinational; the carry is stored by the controller.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one bit pair per clock, LSB first.
// Define SERIAL_ADDER_ACC_EN to add the acc port (held result as operand a).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
`ifdef SERIAL_ADDER_ACC_EN
  input  logic             acc,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;
  logic accept;
  logic last;

  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] op_a;
  logic [CW-1:0] cnt;
  logic carry;
  logic cout_q;
  logic ovf_q;
  logic cell_sum;
  logic cell_cout;

`ifdef SERIAL_ADDER_ACC_EN
  assign op_a = acc ? result : a;
`else
  assign op_a = a;
`endif

  assign last = (cnt == LAST);

  serial_fa_cell u_cell (
    .a    (shift_a[0]),
    .b    (shift_b[0]),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state, accept decision and status outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand load on accept, one bit through the cell per SHIFT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_a <= '0;
      shift_b <= '0;
      result  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      shift_a <= op_a;
      shift_b <= sub ? ~b : b;
      carry   <= sub;
      cnt     <= '0;
    end else if (state == ST_SHIFT) begin
      result  <= {cell_sum, result[WIDTH-1:1]};
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      carry   <= cell_cout;
      cnt     <= cnt + 1'b1;
      if (last) begin
        // carry is the carry into the MSB here.
        cout_q <= cell_cout;
        ovf_q  <= carry ^ cell_cout;
      end
    end
  end

  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=4).
// Build with SERIAL_ADDER_ACC_EN to also exercise accumulate mode.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sub = 1'b0;
`ifdef SERIAL_ADDER_ACC_EN
  logic acc = 1'b0;
`endif
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic busy;
  logic done;
  logic [W-1:0] result;
  logic cout;
  logic overflow;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  vec_t tbl[8];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
`ifdef SERIAL_ADDER_ACC_EN
    .acc      (acc),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic c,
                              input logic o);
    exp_t e;
    e.res  = r;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  // Scoreboard: every done pulse pops and checks one expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("cout", 32'(cout), 32'(e.cout));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  // Drive a request at the current negedge; return at the
  // first negedge after the accepting edge.
  task automatic launch(input logic s, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic ac);
    sub   = s;
    a     = aa;
    b     = bb;
    start = 1'b1;
`ifdef SERIAL_ADDER_ACC_EN
    acc   = ac;
`else
    if (ac) $display("acc request ignored in this build");
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges from the first one after accept until done.
  task automatic wait_done(input string tag, input bit noisy);
    int n;
    int nb;
    bit got;
    n = 0;
    nb = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
        start = 1'b0;
      end else begin
        if (busy) nb++;
        if (noisy) begin
          start = 1'b1;
          sub   = 1'($urandom);
          a     = W'($urandom);
          b     = W'($urandom);
        end
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(W));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 4'b0101, 4'b0100, 4'b1001, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 4'b0111, 4'b0111, 4'b0000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0};

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(tbl[i].res, tbl[i].cout, tbl[i].ovf));
      launch(tbl[i].sub, tbl[i].a, tbl[i].b, 1'b0);
      wait_done($sformatf("vec%0d", i), 1'b0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
    end

    // Starts during SHIFT are ignored; start in DONE chains.
    sb.push_back(mk(4'b1001, 1'b0, 1'b1));
    launch(1'b0, 4'b0101, 4'b0100, 1'b0);
    wait_done("ignore", 1'b1);
    sb.push_back(mk(4'b1110, 1'b0, 1'b0));
    launch(1'b1, 4'b0011, 4'b0101, 1'b0);
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b", 1'b0);
    @(negedge clk);

    // Asynchronous reset in the second SHIFT cycle.
    launch(1'b0, 4'b0110, 4'b0011, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sb.push_back(mk(4'b0010, 1'b0, 1'b0));
    launch(1'b0, 4'b0001, 4'b0001, 1'b0);
    wait_done("post_rst", 1'b0);
    @(negedge clk);

`ifdef SERIAL_ADDER_ACC_EN
    sb.push_back(mk(4'b0010, 1'b0, 1'b0));
    launch(1'b0, 4'b0001, 4'b0001, 1'b0);
    wait_done("acc0", 1'b0);
    @(negedge clk);
    sb.push_back(mk(4'b0101, 1'b0, 1'b0));
    launch(1'b0, 4'b1111, 4'b0011, 1'b1);
    wait_done("acc1", 1'b0);
    @(negedge clk);
    sb.push_back(mk(4'b0000, 1'b1, 1'b0));
    launch(1'b1, 4'b1010, 4'b0101, 1'b1);
    wait_done("acc2", 1'b0);
    @(negedge clk);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell.
- Latches two WIDTH-bit operands on a start handshake.
- Feeds one bit pair per clock through the cell, carry held in a flip-flop.
- Assembles the result LSB-first; reports carry-out and signed overflow.
- Area-saving alternative to the 4-bit ripple chain used in the ALU lab datapath; sits between the ALU control and the register file.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
start  input  1  request a new operation; sampled only in IDLE or DONE.
sub  input  1  0 = a+b, 1 = a-b; sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while bits are being processed (SHIFT state).
done  output  1  one-cycle pulse: result, cout and overflow are valid.
result  output  WIDTH  sum or difference, held until the next accepted start.
cout  output  1  final carry-out. For sub, 1 = no borrow (a >= b unsigned).
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, any state): state=IDLE; bit counter=0; carry FF=0; operand shift registers=0.
  - Outputs on reset: busy=0, done=0, result=0, cout=0, overflow=0.
  - Reset mid-operation aborts the operation; no partial result is retained.
- States, 2-bit encoding:
  - IDLE: wait for start.
  - SHIFT: process one bit per cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Accept: start=1 at a rising edge while state is IDLE or DONE.
  - Load shift_a=a.
  - Load shift_b = sub ? ~b : b.
  - Carry FF = sub.
  - Counter = 0; state -> SHIFT.
- SHIFT, per edge:
  - Cell inputs: shift_a[0], shift_b[0], carry FF.
  - Cell sum shifts into result MSB; result shifts right.
  - shift_a and shift_b shift right; carry FF = cell carry; counter increments.
  - At the edge with counter==WIDTH-1, also:
    - prev-carry FF captures the cell's carry-in, i.e. the carry into the MSB.
    - state -> DONE.
- Latency: start accepted at edge k. Bits processed at edges k+1..k+WIDTH. done=1 during the cycle after edge k+WIDTH.
- Outputs during DONE: cout = carry FF; overflow = carry FF XOR prev-carry FF. Both are registered and held with result until the next accept.
- busy=1 only in SHIFT. start while busy is ignored: no queuing, no effect on the operation in flight.
- Back-to-back: start=1 during DONE is accepted at the edge leaving DONE. State goes DONE -> SHIFT directly; done still pulses only one cycle.
- Arithmetic: modulo 2^WIDTH; no saturation. sub with a==b gives result=0, cout=1, overflow=0.
- result changes only during SHIFT. Partial values are visible then but not valid until done.

Optional Feature:
Macro SERIAL_ADDER_ACC_EN.
- Defined:
  - Adds input port acc (1 bit), sampled with start.
  - acc=1 substitutes the held result for operand a; a is ignored.
  - The held result after reset is 0.
- Undefined: no acc port; operand a is always used.

Decomposition:
- Package serial_adder_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10.
  - Default WIDTH constant.
  - Counter-width helper: $clog2(WIDTH)+1.
- Sub-module serial_fa_cell: combinational 1-bit full adder (a, b, cin -> sum, cout). Instantiated once in the controller's datapath.

Test Plan:
Cases 1-5 use WIDTH=4; the cycle check applies to every case.
1. add a=0101, b=0100 -> result=1001, cout=0, overflow=1. done pulses exactly in the cycle after edge k+4; busy high for 4 cycles.
2. add a=1100, b=0100 -> result=0000, cout=1, overflow=0. Then add a=0000, b=0000 -> result=0000, cout=0, overflow=0.
3. sub a=0011, b=0101 -> result=1110, cout=0 (borrow), overflow=0. Then sub a=0111, b=0111 -> result=0000, cout=1, overflow=0.
4. Start pulses during SHIFT with different operands -> ignored; first result unchanged. Start during the DONE cycle -> accepted; second done exactly 5 edges later with the correct value.
5. reset asserted asynchronously during the 2nd SHIFT cycle -> all outputs 0 immediately, state IDLE. A following add a=0001, b=0001 gives result=0010.
6. With SERIAL_ADDER_ACC_EN:
   - add a=0001, b=0001 -> 0010.
   - Then acc=1, b=0011 -> 0101.
   - Then acc=1, sub=1, b=0101 -> 0000, cout=1.
